// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control path: states, opcodes and ALUOp codes.
package main_fsm_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 7;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/main_fsm_if.sv
// Control bundle between the main FSM (master) and the multicycle datapath (slave).
interface main_fsm_if;
  import main_fsm_pkg::*;

  logic [OP_W-1:0]    op;
  logic               Zero;
  logic [SEL_W-1:0]   ALUOp;
  logic [SEL_W-1:0]   ALUSrcA;
  logic [SEL_W-1:0]   ALUSrcB;
  logic [SEL_W-1:0]   ResultSrc;
  logic               AdrSrc;
  logic               IRWrite;
  logic               RegWrite;
  logic               MemWrite;
  logic               PCWrite;
  logic [STATE_W-1:0] state;

  modport master (
    input  op, Zero,
    output ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
           IRWrite, RegWrite, MemWrite, PCWrite, state
  );

  modport slave (
    output op, Zero,
    input  ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
           IRWrite, RegWrite, MemWrite, PCWrite, state
  );
endinterface

// File: rtl/fsm_output_decoder.sv
// Moore output decode for the main FSM; only PCWrite also looks at Zero.
// Reset masks the write enables combinationally, selects stay state-decoded.
module fsm_output_decoder
  import main_fsm_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic               Zero,
  input  logic               reset,
  output logic [SEL_W-1:0]   ALUOp,
  output logic [SEL_W-1:0]   ALUSrcA,
  output logic [SEL_W-1:0]   ALUSrcB,
  output logic [SEL_W-1:0]   ResultSrc,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               PCWrite
);

  logic ir_write;
  logic reg_write;
  logic mem_write;
  logic pc_update;
  logic branch;

  always_comb begin
    ALUOp     = ALUOP_ADD;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    case (state)
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = ALUOP_SUB;
        branch  = 1'b1;
      end
      // FETCH and the unused codes 11..15 share the fetch decode
      default: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = 1'b1;
        pc_update = 1'b1;
      end
    endcase
  end

  assign IRWrite  = ir_write  & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign PCWrite  = (pc_update | (branch & Zero)) & ~reset;

endmodule

// File: rtl/main_fsm.sv
// Main control FSM for the multicycle RV32I datapath: state register and next-state logic.
module main_fsm
  import main_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  main_fsm_if.master bus
);

  state_t state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYPE:     state_q <= S_EXECUTER;
            OP_ITYPE:     state_q <= S_EXECUTEI;
            OP_JAL:       state_q <= S_JAL;
            OP_BEQ:       state_q <= S_BEQ;
            default:      state_q <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          if (bus.op == OP_LW)      state_q <= S_MEMREAD;
          else if (bus.op == OP_SW) state_q <= S_MEMWRITE;
          else                      state_q <= S_FETCH;
        end
        S_MEMREAD:  state_q <= S_MEMWB;
        S_EXECUTER: state_q <= S_ALUWB;
        S_EXECUTEI: state_q <= S_ALUWB;
        S_JAL:      state_q <= S_ALUWB;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  assign bus.state = STATE_W'(state_q);

  fsm_output_decoder u_dec (
    .state     (STATE_W'(state_q)),
    .Zero      (bus.Zero),
    .reset     (reset),
    .ALUOp     (bus.ALUOp),
    .ALUSrcA   (bus.ALUSrcA),
    .ALUSrcB   (bus.ALUSrcB),
    .ResultSrc (bus.ResultSrc),
    .AdrSrc    (bus.AdrSrc),
    .IRWrite   (bus.IRWrite),
    .RegWrite  (bus.RegWrite),
    .MemWrite  (bus.MemWrite),
    .PCWrite   (bus.PCWrite)
  );

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: per-opcode state walks with hand-tabulated control words.
module tb_main_fsm;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  main_fsm_if bus ();

  main_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {ALUOp,ALUSrcA,ALUSrcB,ResultSrc,AdrSrc,IRWrite,RegWrite,MemWrite,PCWrite}
  function automatic logic [12:0] exp_ctrl(input int st, input logic z);
    case (st)
      1:  exp_ctrl = {2'b00, 2'b01, 2'b01, 2'b00, 5'b00000};
      2:  exp_ctrl = {2'b00, 2'b10, 2'b01, 2'b00, 5'b00000};
      3:  exp_ctrl = {2'b00, 2'b00, 2'b00, 2'b00, 5'b10000};
      4:  exp_ctrl = {2'b00, 2'b00, 2'b00, 2'b01, 5'b00100};
      5:  exp_ctrl = {2'b00, 2'b00, 2'b00, 2'b00, 5'b10010};
      6:  exp_ctrl = {2'b10, 2'b10, 2'b00, 2'b00, 5'b00000};
      7:  exp_ctrl = {2'b00, 2'b00, 2'b00, 2'b00, 5'b00100};
      8:  exp_ctrl = {2'b10, 2'b10, 2'b01, 2'b00, 5'b00000};
      9:  exp_ctrl = {2'b00, 2'b01, 2'b10, 2'b00, 5'b00001};
      10: exp_ctrl = {2'b01, 2'b10, 2'b00, 2'b00, 4'b0000, z};
      default: exp_ctrl = {2'b00, 2'b00, 2'b10, 2'b10, 5'b01001};
    endcase
  endfunction

  function automatic logic [12:0] got_ctrl();
    got_ctrl = {bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc,
                bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.PCWrite};
  endfunction

  // Walk one instruction from FETCH; seq holds the expected state per cycle, ending in FETCH.
  task automatic run_seq(input string tag, input logic [6:0] opc, input logic z,
                         input int seq[6], input int n);
    bus.op   = opc;
    bus.Zero = z;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_state%0d", tag, i), 32'(bus.state), 32'(seq[i]));
      check($sformatf("%s_ctrl%0d", tag, i), 32'(got_ctrl()), 32'(exp_ctrl(seq[i], z)));
      if (i < n - 1) step();
    end
  endtask

  initial begin
    reset    = 1'b1;
    bus.op   = 7'b0000011;
    bus.Zero = 1'b0;
    step();
    step();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_writes", 32'({bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.PCWrite}), 32'd0);
    check("rst_selb", 32'(bus.ALUSrcB), 32'd2);

    reset = 1'b0;
    #1;
    check("rel_irwrite", 32'(bus.IRWrite), 32'd1);
    check("rel_pcwrite", 32'(bus.PCWrite), 32'd1);
    check("rel_selb", 32'(bus.ALUSrcB), 32'd2);
    check("rel_result", 32'(bus.ResultSrc), 32'd2);

    run_seq("lw",   7'b0000011, 1'b0, '{0, 1, 2, 3, 4, 0}, 6);
    run_seq("sw",   7'b0100011, 1'b0, '{0, 1, 2, 5, 0, 0}, 5);
    run_seq("rtyp", 7'b0110011, 1'b0, '{0, 1, 6, 7, 0, 0}, 5);
    run_seq("beq1", 7'b1100011, 1'b1, '{0, 1, 10, 0, 0, 0}, 4);
    run_seq("beq0", 7'b1100011, 1'b0, '{0, 1, 10, 0, 0, 0}, 4);
    run_seq("jal",  7'b1101111, 1'b0, '{0, 1, 9, 7, 0, 0}, 5);
    run_seq("ityp", 7'b0010011, 1'b0, '{0, 1, 8, 7, 0, 0}, 5);
    run_seq("unk",  7'b1111111, 1'b0, '{0, 1, 0, 0, 0, 0}, 3);

    // Zero must not leak into PCWrite outside BEQ
    bus.Zero = 1'b1;
    bus.op   = 7'b0110011;
    step();
    check("zero_dec_pcw", 32'(bus.PCWrite), 32'd0);
    step();
    check("zero_exr_pcw", 32'(bus.PCWrite), 32'd0);
    step();
    step();
    check("zero_back_fetch", 32'(bus.state), 32'd0);
    bus.Zero = 1'b0;

    // Reset while in MEMWRITE
    bus.op = 7'b0100011;
    step();
    step();
    step();
    check("mid_state5", 32'(bus.state), 32'd5);
    check("mid_mw_pre", 32'(bus.MemWrite), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_mw_rst", 32'(bus.MemWrite), 32'd0);
    check("mid_adrsrc", 32'(bus.AdrSrc), 32'd1);
    step();
    check("mid_state0", 32'(bus.state), 32'd0);
    check("mid_ir_rst", 32'(bus.IRWrite), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_ir_rel", 32'(bus.IRWrite), 32'd1);
    step();
    check("mid_decode", 32'(bus.state), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
